// File: rtl/shift_add_datapath_if.sv
// Strobe/operand/status bundle between the control sequencer (master)
// and the shift-and-add multiplier datapath (slave).
interface shift_add_datapath_if #(
    parameter int WIDTH = 8
);
    logic                 S0, S1, S2, S3, S4, S5;
    logic                 START;
    logic [WIDTH-1:0]     A_IN;
    logic [WIDTH-1:0]     B_IN;
    logic                 GO;
    logic                 SKIP;
    logic [2*WIDTH-1:0]   PRODUCT;
    logic                 DONE;
    logic                 ERR;

    modport master (
        output S0, S1, S2, S3, S4, S5, START, A_IN, B_IN,
        input  GO, SKIP, PRODUCT, DONE, ERR
    );

    modport slave (
        input  S0, S1, S2, S3, S4, S5, START, A_IN, B_IN,
        output GO, SKIP, PRODUCT, DONE, ERR
    );
endinterface

// File: rtl/shift_add_datapath.sv
// Shift-and-add multiplier datapath driven by one-hot sequencer strobes S0..S5;
// owns all operand/accumulator registers and the GO/SKIP/DONE/ERR status bits.
module shift_add_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    shift_add_datapath_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             carry_q,  carry_d;
    logic [WIDTH:0]   sum_q,    sum_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             loaded_q, loaded_d;
    logic             go_q,     go_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;

    logic [5:0] strb;
    logic [2:0] n_strb;
    logic       multi;

    assign strb = {bus.S5, bus.S4, bus.S3, bus.S2, bus.S1, bus.S0};

    always_comb begin
        n_strb = '0;
        for (int i = 0; i < 6; i++) n_strb = n_strb + {2'b00, strb[i]};
    end

    assign multi = (n_strb > 3'd1);

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        count_d  = count_q;
        loaded_d = loaded_q;
        go_d     = go_q;
        done_d   = done_q;
        err_d    = err_q;
        if (multi) begin
            // Conflicting strobes freeze the datapath; only the sticky flag moves.
            err_d = 1'b1;
        end else begin
            if (bus.START) go_d = 1'b1;
            if (bus.S0) begin
                mcand_d  = '0;
                acc_d    = '0;
                mplier_d = '0;
                carry_d  = 1'b0;
                sum_d    = '0;
                count_d  = '0;
                loaded_d = 1'b0;
                done_d   = 1'b0;
                err_d    = 1'b0;
            end
            // First S1 after S0 loads; later S1s are loop re-entries and hold.
            if (bus.S1 && !loaded_q) begin
                mcand_d  = bus.A_IN;
                mplier_d = bus.B_IN;
                acc_d    = '0;
                count_d  = CW'(WIDTH);
                loaded_d = 1'b1;
                go_d     = 1'b0;
            end
            if (bus.S3 && !done_q) sum_d = {1'b0, acc_q} + {1'b0, mcand_q};
            if (bus.S4 && !done_q) begin
                acc_d   = sum_q[WIDTH-1:0];
                carry_d = sum_q[WIDTH];
            end
            if (bus.S5 && !done_q) begin
                acc_d    = {carry_q, acc_q[WIDTH-1:1]};
                mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
                carry_d  = 1'b0;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            count_q  <= '0;
            loaded_q <= 1'b0;
            go_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            count_q  <= count_d;
            loaded_q <= loaded_d;
            go_q     <= go_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.GO      = go_q;
    assign bus.SKIP    = ~mplier_q[0] | done_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;
    assign bus.PRODUCT = {acc_q, mplier_q};
endmodule

// File: tb/tb_shift_add_datapath.sv
// Bench acting as the control sequencer; a product-level model predicts every
// output each cycle, and literal expectations pin the headline results.
module tb_shift_add_datapath;
    localparam int W = 8;
    localparam logic [5:0] P0 = 6'b000001, P1 = 6'b000010, P2 = 6'b000100;
    localparam logic [5:0] P3 = 6'b001000, P4 = 6'b010000, P5 = 6'b100000;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    shift_add_datapath_if #(.WIDTH(W)) bus();
    shift_add_datapath #(.WIDTH(W)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model state: operands captured, multiplier bits retired, add pending.
    logic         m_loaded = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    int           m_k = 0;
    logic         m_added = 1'b0;
    logic         m_go = 1'b0;
    logic         m_done = 1'b0;
    logic         m_err = 1'b0;

    // Literal-expectation mailbox: main process posts, compare process checks.
    string        pin_nm = "";
    logic [31:0]  pin_act = '0;
    logic [31:0]  pin_exp = '0;
    logic         pin_tog = 1'b0;
    logic         pin_seen = 1'b0;

    function automatic logic [2*W-1:0] exp_prod();
        logic [31:0] p;
        if (!m_loaded) return '0;
        p = ((32'(m_a) * (32'(m_b) & ((32'd1 << m_k) - 32'd1))) << (W - m_k))
            | (32'(m_b) >> m_k);
        if (m_added) p = p + (32'(m_a) << W);
        return p[2*W-1:0];
    endfunction

    function automatic logic exp_skip();
        if (!m_loaded || m_done) return 1'b1;
        return ((m_b >> m_k) & 8'd1) == 8'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        logic [5:0] s;
        forever begin
            @(negedge CLK);
            chk("GO", 32'(bus.GO), 32'(m_go));
            chk("SKIP", 32'(bus.SKIP), 32'(exp_skip()));
            chk("PRODUCT", 32'(bus.PRODUCT), 32'(exp_prod()));
            chk("DONE", 32'(bus.DONE), 32'(m_done));
            chk("ERR", 32'(bus.ERR), 32'(m_err));
            if (pin_tog != pin_seen) begin
                pin_seen = pin_tog;
                chk(pin_nm, pin_act, pin_exp);
            end
            // Predict the state after the coming edge from the applied inputs.
            s = {bus.S5, bus.S4, bus.S3, bus.S2, bus.S1, bus.S0};
            if (RESET) begin
                m_loaded = 0; m_a = '0; m_b = '0; m_k = 0; m_added = 0;
                m_go = 0; m_done = 0; m_err = 0;
            end else if ($countones(s) > 1) begin
                m_err = 1;
            end else begin
                if (bus.START) m_go = 1;
                if (s[0]) begin
                    m_loaded = 0; m_a = '0; m_b = '0; m_k = 0; m_added = 0;
                    m_done = 0; m_err = 0;
                end
                if (s[1] && !m_loaded) begin
                    m_loaded = 1; m_a = bus.A_IN; m_b = bus.B_IN; m_k = 0;
                    m_added = 0; m_go = 0;
                end
                if (s[4] && !m_done) m_added = 1;
                if (s[5] && !m_done) begin
                    m_k++;
                    m_added = 0;
                    if (m_k == W) m_done = 1;
                end
            end
        end
    end

    task automatic step(input logic [5:0] s, input logic st, input logic rst);
        {bus.S5, bus.S4, bus.S3, bus.S2, bus.S1, bus.S0} = s;
        bus.START = st;
        RESET = rst;
        @(posedge CLK); #1;
        {bus.S5, bus.S4, bus.S3, bus.S2, bus.S1, bus.S0} = '0;
        bus.START = 1'b0;
        RESET = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        pin_nm = nm;
        pin_act = act;
        pin_exp = exp;
        pin_tog = ~pin_tog;
        @(posedge CLK); #1;
    endtask

    task automatic sc(input logic [5:0] s, inout int cnt, inout int dc);
        step(s, 1'b0, 1'b0);
        cnt++;
        if (dc < 0 && bus.DONE) dc = cnt;
    endtask

    // Sequencer: walks the multiplier bits of b, optionally injecting a
    // conflicting strobe cycle or aborting with RESET during an S4.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int bad_at, input int abort_at, output int done_cyc);
        int cnt;
        cnt = 0;
        done_cyc = -1;
        bus.A_IN = a;
        bus.B_IN = b;
        for (int i = 0; i < W; i++) begin
            sc(P1, cnt, done_cyc);
            sc(P2, cnt, done_cyc);
            if (b[i]) begin
                sc(P3, cnt, done_cyc);
                if (i == abort_at) begin
                    step(P4, 1'b0, 1'b1);
                    return;
                end
                sc(P4, cnt, done_cyc);
            end
            if (i == bad_at) begin
                step(P3 | P5, 1'b0, 1'b0);
                lit("err_set", 32'(bus.ERR), 32'd1);
            end
            sc(P5, cnt, done_cyc);
        end
        for (int j = 0; j < 2; j++) begin
            sc(P1, cnt, done_cyc);
            sc(P2, cnt, done_cyc);
            sc(P5, cnt, done_cyc);
        end
    endtask

    task automatic prep();
        step('0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0);
        step(P0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        {bus.S5, bus.S4, bus.S3, bus.S2, bus.S1, bus.S0} = '0;
        bus.START = 1'b0;
        bus.A_IN = '0;
        bus.B_IN = '0;
        @(posedge CLK); #1;
        step('0, 1'b0, 1'b1);
        lit("rst_prod", 32'(bus.PRODUCT), 32'd0);
        lit("rst_skip", 32'(bus.SKIP), 32'd1);
        lit("rst_go", 32'(bus.GO), 32'd0);
        lit("rst_done", 32'(bus.DONE), 32'd0);

        prep();
        run(8'h0F, 8'h0F, -1, -1, cyc);
        lit("nom_prod", 32'(bus.PRODUCT), 32'h00E1);
        lit("nom_cyc", 32'(cyc), 32'd32);

        prep();
        run(8'hFF, 8'hFF, -1, -1, cyc);
        lit("max_prod", 32'(bus.PRODUCT), 32'hFE01);
        lit("max_cyc", 32'(cyc), 32'd40);

        prep();
        run(8'hAB, 8'h00, -1, -1, cyc);
        lit("zero_prod", 32'(bus.PRODUCT), 32'h0000);
        lit("zero_cyc", 32'(cyc), 32'd24);

        prep();
        run(8'h12, 8'h34, -1, 2, cyc);
        lit("abort_acc", 32'(bus.PRODUCT[15:8]), 32'd0);
        lit("abort_done", 32'(bus.DONE), 32'd0);
        lit("abort_go", 32'(bus.GO), 32'd0);
        lit("abort_err", 32'(bus.ERR), 32'd0);
        step('0, 1'b1, 1'b0);
        step(P0, 1'b0, 1'b0);
        run(8'h12, 8'h34, -1, -1, cyc);
        lit("rerun_prod", 32'(bus.PRODUCT), 32'h03A8);
        lit("rerun_cyc", 32'(cyc), 32'd30);

        prep();
        run(8'h5A, 8'h3C, 3, -1, cyc);
        lit("ill_prod", 32'(bus.PRODUCT), 32'h1518);
        lit("ill_sticky", 32'(bus.ERR), 32'd1);
        step(P0, 1'b0, 1'b0);
        lit("ill_clr", 32'(bus.ERR), 32'd0);

        step('0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b0);
        lit("go_set", 32'(bus.GO), 32'd1);
        lit("go_hold", 32'(bus.GO), 32'd1);
        step(P0, 1'b0, 1'b0);
        lit("go_s0", 32'(bus.GO), 32'd1);
        bus.A_IN = 8'h03;
        bus.B_IN = 8'h05;
        step(P1, 1'b0, 1'b0);
        lit("go_clr_s1", 32'(bus.GO), 32'd0);
        step(P0, 1'b0, 1'b0);
        step(P1, 1'b1, 1'b0);
        lit("go_lost", 32'(bus.GO), 32'd0);
        lit("go_load_prod", 32'(bus.PRODUCT), 32'h0005);

        @(negedge CLK); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
